// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers with bounded
// bursts, conservative full/almostfull back-pressure and wr_ack/overflow checking.
//
// state | meaning
// IDLE  | search requesters from ptr; grant the first one if the FIFO can take a word
// BURST | owner keeps the port until MAX_BURST words are written or it drops req
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          full,
    input  logic                          almostfull,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic [FIFO_WIDTH-1:0]         data_in,
    output logic                          wr_en,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy,
    output logic [15:0]                   ack_cnt,
    output logic                          ack_err,
    output logic                          ovf_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   owner_nxt;
    logic [CW-1:0]   burst_cnt, burst_cnt_nxt;
    logic [IW-1:0]   sel, idx, cur;
    logic            can_wr, xfer, prev_wr_en;
    logic [FIFO_WIDTH-1:0] cur_data;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // The word already on wr_en lands before a new one, so almostfull blocks issue.
    assign can_wr = !full && !(almostfull && wr_en);

    always_comb begin
        sel = ptr;
        idx = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[idx] && sel == ptr && !req[ptr]) sel = idx;
            idx = next_idx(idx);
        end
        if (req[ptr]) sel = ptr;
    end

    always_comb begin
        cur = (state == BURST) ? owner : sel;
        gnt = '0;
        if (!rst && can_wr) begin
            if (state == IDLE && |req) gnt[sel] = 1'b1;
            else if (state == BURST && req[owner]) gnt[owner] = 1'b1;
        end
    end

    assign xfer     = |(req & gnt);
    assign cur_data = req_data[int'(cur)*FIFO_WIDTH +: FIFO_WIDTH];
    assign busy     = (state == BURST);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    owner_nxt     = sel;
                    burst_cnt_nxt = CW'(1);
                    if (MAX_BURST == 1) ptr_nxt = next_idx(sel);
                    else state_nxt = BURST;
                end
            end
            BURST: begin
                if (!req[owner]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = next_idx(owner);
                end else if (xfer) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    if (burst_cnt + 1'b1 == BURST_MAX) begin
                        state_nxt = IDLE;
                        ptr_nxt   = next_idx(owner);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            burst_cnt  <= '0;
            wr_en      <= 1'b0;
            data_in    <= '0;
            prev_wr_en <= 1'b0;
            ack_cnt    <= '0;
            ack_err    <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            owner      <= owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
            wr_en      <= xfer;
            if (xfer) data_in <= cur_data;
            prev_wr_en <= wr_en;
            if (wr_ack) ack_cnt <= ack_cnt + 1'b1;
            if (prev_wr_en && !wr_ack) ack_err <= 1'b1;
            if (overflow) ovf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small depth-8 FIFO model on the write side.
module tb_fifo_wr_arbiter;
    localparam int W = 16;
    localparam int N = 4;
    localparam int DEPTH = 8;

    logic           clk, rst;
    logic [N-1:0]   req, gnt;
    logic [N*W-1:0] req_data;
    logic           full, almostfull, wr_ack, overflow;
    logic [W-1:0]   data_in;
    logic           wr_en, busy, ack_err, ovf_err;
    logic [1:0]     owner;
    logic [15:0]    ack_cnt;

    logic [W-1:0]   rdat [N];
    logic           rd, drop_ack, ovf_inject, ovf_flag, ovf_seen;
    int             fcnt;
    int             n_tests = 0;
    int             n_fail = 0;

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .full(full), .almostfull(almostfull), .wr_ack(wr_ack), .overflow(overflow),
        .data_in(data_in), .wr_en(wr_en), .owner(owner), .busy(busy),
        .ack_cnt(ack_cnt), .ack_err(ack_err), .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = rdat[i];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt     <= 0;
            wr_ack   <= 1'b0;
            ovf_flag <= 1'b0;
            ovf_seen <= 1'b0;
        end else begin
            wr_ack   <= wr_en && (fcnt < DEPTH) && !drop_ack;
            ovf_flag <= wr_en && (fcnt == DEPTH);
            fcnt     <= fcnt + ((wr_en && fcnt < DEPTH) ? 1 : 0) - ((rd && fcnt > 0) ? 1 : 0);
            if (overflow) ovf_seen <= 1'b1;
        end
    end

    assign full       = (fcnt == DEPTH);
    assign almostfull = (fcnt == DEPTH - 1);
    assign overflow   = ovf_flag | ovf_inject;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nwr;
        logic granted;
        logic [N-1:0] eg;

        rst = 1'b1; rd = 1'b1; drop_ack = 1'b0; ovf_inject = 1'b0;
        req = 4'b1111;
        rdat[0] = 16'hA0A0; rdat[1] = 16'hB1B1; rdat[2] = 16'hC2C2; rdat[3] = 16'hD3D3;

        // reset held for 3 cycles with all requests up
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_data_in", 32'(data_in), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack_cnt", 32'(ack_cnt), 32'h0);
        chk("rst_ack_err", 32'(ack_err), 32'h0);
        chk("rst_ovf_err", 32'(ovf_err), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_first_gnt", 32'(gnt), 32'h1);

        // round robin with full bursts, FIFO drained every cycle
        for (int t = 0; t < 17; t++) begin
            eg = 4'(1 << ((t / 4) % 4));
            chk("rr_gnt", 32'(gnt), 32'(eg));
            tick();
            chk("rr_wr_en", 32'(wr_en), 32'h1);
            chk("rr_data", 32'(data_in), 32'(rdat[(t / 4) % 4]));
        end
        req = 4'b0000;
        tick();
        chk("rr_ack_cnt", 32'(ack_cnt), 32'd16);
        chk("rr_ack_err", 32'(ack_err), 32'h0);
        repeat (2) tick();

        // owner drop: requester 1 writes twice then releases
        req = 4'b0010;
        #1;
        chk("drop_gnt1a", 32'(gnt), 32'h2);
        tick();
        chk("drop_wr1a", 32'(data_in), 32'(rdat[1]));
        chk("drop_gnt1b", 32'(gnt), 32'h2);
        tick();
        chk("drop_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        #1;
        chk("drop_gnt_low", 32'(gnt), 32'h0);
        tick();
        chk("drop_no_xfer", 32'(wr_en), 32'h0);
        req = 4'b0101;
        #1;
        chk("drop_next_is2", 32'(gnt), 32'h4);
        tick();
        chk("drop_owner2", 32'(owner), 32'h2);
        req = 4'b0001;
        #1;
        chk("drop2_gnt_low", 32'(gnt), 32'h0);
        tick();
        chk("drop_then0", 32'(gnt), 32'h1);
        req = 4'b0000;
        repeat (3) tick();

        // full back-pressure: no reads, requester 3 streams incrementing data
        rd = 1'b0;
        rdat[3] = 16'h3000;
        req = 4'b1000;
        nwr = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            granted = gnt[3] && req[3];
            tick();
            if (wr_en) nwr++;
            if (granted) rdat[3] = rdat[3] + 16'h1;
        end
        chk("bp_writes", 32'(nwr), 32'd8);
        chk("bp_gnt_full", 32'(gnt), 32'h0);
        chk("bp_last_data", 32'(data_in), 32'h3007);
        chk("bp_ovf_seen", 32'(ovf_seen), 32'h0);
        chk("bp_ovf_err", 32'(ovf_err), 32'h0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            granted = gnt[3] && req[3];
            tick();
            if (wr_en) nwr++;
            if (granted) rdat[3] = rdat[3] + 16'h1;
        end
        chk("bp_one_more", 32'(nwr), 32'd1);
        chk("bp_data8", 32'(data_in), 32'h3008);
        chk("bp_ovf_seen2", 32'(ovf_seen), 32'h0);
        req = 4'b0000;
        rd = 1'b1;
        repeat (10) tick();

        // error flags: one missing ack, then one overflow pulse
        req = 4'b0001;
        #1;
        chk("err_gnt", 32'(gnt), 32'h1);
        tick();
        drop_ack = 1'b1;
        req = 4'b0000;
        tick();
        drop_ack = 1'b0;
        chk("err_ack_pre", 32'(ack_err), 32'h0);
        tick();
        chk("err_ack_set", 32'(ack_err), 32'h1);
        chk("err_ovf_pre", 32'(ovf_err), 32'h0);
        ovf_inject = 1'b1;
        tick();
        ovf_inject = 1'b0;
        chk("err_ovf_set", 32'(ovf_err), 32'h1);
        repeat (3) tick();
        chk("err_ack_sticky", 32'(ack_err), 32'h1);
        chk("err_ovf_sticky", 32'(ovf_err), 32'h1);

        // reset in the middle of a burst by requester 2
        req = 4'b0100;
        #1;
        chk("mid_gnt2", 32'(gnt), 32'h4);
        tick();
        tick();
        chk("mid_owner", 32'(owner), 32'h2);
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_wr_en", 32'(wr_en), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_flags", 32'({ack_err, ovf_err}), 32'h0);
        chk("mid_rst_ack_cnt", 32'(ack_cnt), 32'h0);
        tick();
        rst = 1'b0;
        req = 4'b0101;
        #1;
        chk("mid_first_gnt", 32'(gnt), 32'h1);
        tick();
        chk("mid_wr_en_after", 32'(wr_en), 32'h1);
        chk("mid_data0", 32'(data_in), 32'(rdat[0]));
        chk("mid_owner0", 32'(owner), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one synchronous FIFO write port between NUM_REQ producers. Each producer gets a bounded burst of up to MAX_BURST words before priority rotates. Writes are issued only when the FIFO can accept them, so overflow never occurs in normal operation. The block also checks the FIFO's wr_ack/overflow responses and keeps a write-acknowledge count. It sits directly in front of the FIFO write side and drives its data_in/wr_en.

## Interface
- FIFO_WIDTH, 16 (from shared_pkg): data word width
- NUM_REQ, 4: number of requesters, ≥2
- MAX_BURST, 4: maximum consecutive transfers per grant, ≥1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester valid; requester i holds req[i] and its data until transferred
- req_data  in  NUM_REQ*FIFO_WIDTH  requester i word at bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- gnt  out  NUM_REQ  combinational one-hot ready; transfer of requester i occurs at an edge where req[i] && gnt[i]
- full  in  1  FIFO full
- almostfull  in  1  FIFO holds FIFO_DEPTH-1 words
- wr_ack  in  1  FIFO write acknowledge, one cycle after accepted wr_en
- overflow  in  1  FIFO overflow flag
- data_in  out  FIFO_WIDTH  registered write data to FIFO
- wr_en  out  1  registered write enable to FIFO
- owner  out  $clog2(NUM_REQ)  current or last burst owner
- busy  out  1  state == BURST
- ack_cnt  out  16  count of wr_ack cycles, wraps modulo 2^16
- ack_err  out  1  sticky: wr_en in cycle k without wr_ack in cycle k+1
- ovf_err  out  1  sticky: overflow seen high

## Operation
- Issue condition: can_wr = !full && !(almostfull && wr_en). This is conservative because the write already in flight lands before the new one. Reads can only make it looser.
- States: IDLE, BURST. Registers: ptr (round-robin pointer), owner, burst_cnt (0..MAX_BURST).
- IDLE:
  - sel = first i with req[i], searching ptr, ptr+1, … modulo NUM_REQ.
  - gnt = onehot(sel) if any req && can_wr, else 0.
- IDLE, on transfer:
  - owner ← sel, burst_cnt ← 1.
  - If MAX_BURST == 1: stay IDLE, ptr ← sel+1. Otherwise go to BURST.
- BURST, gnt logic: gnt = onehot(owner) if req[owner] && can_wr, else 0.
- BURST, owner transfers:
  - burst_cnt increments.
  - If the new count equals MAX_BURST: go to IDLE, ptr ← owner+1.
- BURST, req[owner] low: go to IDLE, ptr ← owner+1, no transfer that cycle.
- BURST, stall (req[owner] && !can_wr): hold state; burst_cnt unchanged.
- On every transfer edge: wr_en ← 1 and data_in ← the granted word. On any other edge: wr_en ← 0, data_in holds its value.
- Pointer arithmetic is modulo NUM_REQ (NUM_REQ-1 wraps to 0). Other requesters are never granted during BURST.
- Checking:
  - ack_cnt increments on each cycle with wr_ack high.
  - ack_err sets if wr_en was high last cycle and wr_ack is low this cycle.
  - ovf_err sets on overflow high.
  - Both error flags clear only on rst.

## Timing
- Reset (async, immediate) values:
  - Outputs: wr_en=0, data_in=0, owner=0, busy=0, ack_cnt=0, ack_err=0, ovf_err=0.
  - Internal: state=IDLE, ptr=0, burst_cnt=0.
  - gnt=0 while rst is high.
- Reset asserted mid-burst: wr_en drops at once; the in-flight word is discarded. After release, arbitration starts from requester 0.
- Latency: a word transferred at edge k appears on data_in/wr_en during cycle k..k+1. Its wr_ack is expected during cycle k+1..k+2.
- Throughput: one word per cycle while can_wr holds, including across burst boundaries. A burst ending on MAX_BURST hands over in IDLE in the same cycle with no bubble.
- An owner drop costs the cycle in which req[owner] is low, and no transfer occurs in it.
- Requester handshake: data may change only after an edge where req[i] && gnt[i]. req is not required to stay high after a transfer.
- Near full: with almostfull high and wr_en high, gnt is 0 for that cycle. The FIFO fills to exactly FIFO_DEPTH and never overflows.

## Test plan
- **Reset:** assert rst for 3 cycles with req=4'b1111 → gnt=0, wr_en=0, all counters and flags 0. After release, the first grant goes to requester 0.
- **Round robin with bursts:** req=4'b1111 held, FIFO drained every cycle, MAX_BURST=4.
  - Grant order is 0,0,0,0,1,1,1,1,2,…,3,3,0 with wr_en high every cycle.
  - ack_cnt=16 one cycle after the 16th write; ack_err=0.
- **Owner drop:** only req[1] is high for 2 transfers, then drops; the next cycle req[0] and req[2] go high.
  - The drop cycle has no transfer; ptr=2.
  - Requester 2 is granted before requester 0.
- **Full back-pressure:** FIFO_DEPTH=8, no reads, req[3] held with incrementing data.
  - Exactly 8 writes, then gnt=0 and overflow never high, ovf_err=0.
  - One read → exactly one more write after the full flag drops.
- **Error flags:** the FIFO model suppresses wr_ack for one write, then pulses overflow once.
  - ack_err=1 the cycle after the missing ack; ovf_err=1 the cycle after overflow.
  - Both stay 1 until rst.
- **Reset mid-burst:** pulse rst while owner=2, burst_cnt=2, wr_en=1.
  - wr_en=0 immediately, busy=0.
  - After release with req=4'b0101, requester 0 is granted first.
